mdu_ctrl: RTL and testbench

Multi-cycle multiply/divide unit for the pipelined MIPS core. Sits in the E stage next to the comparator and ALU, owns the HI/LO registers, and sequences MULT/MULTU/DIV/DIVU as fixed-latency operations. It exports a busy/stall indication for the hazard unit and a cancel input so that a flushed instruction never starts an operation.

---
 rtl/mdu_ctrl.sv | 170 +++++++++++++++++
 tb/tb_mdu_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: E-stage multiply/divide unit that owns HI/LO and sequences
// MULT/MULTU/DIV/DIVU as fixed-latency operations with a stall output for the hazard unit.
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  operation,
  input  logic [31:0] operand1,
  input  logic [31:0] operand2,
  input  logic        cancel,
  output logic        busy,
  output logic        stall,
  output logic [31:0] result
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MFHI  = 4'd7,
    OP_MFLO  = 4'd8
  } mdu_op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] counter, counter_next;
  logic [31:0]   hi, lo, hi_next, lo_next;
  logic [31:0]   op_a, op_b;
  logic          op_signed;
  logic          latch_en, latch_signed;

  mdu_op_t       op;
  logic          is_mdu_op, is_accept_op, accept;

  logic          a_neg, b_neg, div_by_zero;
  logic [31:0]   a_mag, b_mag, b_safe, uq, ur, div_q, div_r;
  logic [63:0]   ext_a, ext_b, product;

  assign op = mdu_op_t'(operation);

  always_comb begin
    is_mdu_op    = (operation >= 4'd1) && (operation <= 4'd8);
    is_accept_op = (operation >= 4'd1) && (operation <= 4'd6);
    busy         = (counter != '0);
    stall        = start && is_mdu_op && busy;
    accept       = start && !cancel && !stall && is_accept_op;
  end

  // Datapath works on the latched operands so the E-stage inputs may change while busy.
  always_comb begin
    a_neg       = op_signed & op_a[31];
    b_neg       = op_signed & op_b[31];
    a_mag       = a_neg ? (~op_a + 32'd1) : op_a;
    b_mag       = b_neg ? (~op_b + 32'd1) : op_b;
    div_by_zero = (op_b == 32'd0);
    b_safe      = div_by_zero ? 32'd1 : b_mag;
    uq          = a_mag / b_safe;
    ur          = a_mag % b_safe;
    div_q       = (a_neg ^ b_neg) ? (~uq + 32'd1) : uq;
    div_r       = a_neg ? (~ur + 32'd1) : ur;
    ext_a       = op_signed ? {{32{op_a[31]}}, op_a} : {32'd0, op_a};
    ext_b       = op_signed ? {{32{op_b[31]}}, op_b} : {32'd0, op_b};
    product     = ext_a * ext_b;
  end

  always_comb begin
    state_next   = state;
    counter_next = counter;
    hi_next      = hi;
    lo_next      = lo;
    latch_en     = 1'b0;
    latch_signed = op_signed;

    case (state)
      S_IDLE: begin
        if (accept) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              state_next   = S_MUL;
              counter_next = CW'(MULT_CYCLES);
              latch_en     = 1'b1;
              latch_signed = (op == OP_MULT);
            end
            OP_DIV, OP_DIVU: begin
              state_next   = S_DIV;
              counter_next = CW'(DIV_CYCLES);
              latch_en     = 1'b1;
              latch_signed = (op == OP_DIV);
            end
            OP_MTHI: hi_next = operand1;
            OP_MTLO: lo_next = operand1;
            default: ;
          endcase
        end
      end

      S_MUL: begin
        counter_next = counter - CW'(1);
        if (counter == CW'(1)) begin
          state_next = S_IDLE;
          hi_next    = product[63:32];
          lo_next    = product[31:0];
        end
      end

      // A zero divisor still burns the full latency but leaves HI/LO alone.
      S_DIV: begin
        counter_next = counter - CW'(1);
        if (counter == CW'(1)) begin
          state_next = S_IDLE;
          if (!div_by_zero) begin
            hi_next = div_r;
            lo_next = div_q;
          end
        end
      end

      default: begin
        state_next   = S_IDLE;
        counter_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      counter   <= '0;
      hi        <= 32'd0;
      lo        <= 32'd0;
      op_a      <= 32'd0;
      op_b      <= 32'd0;
      op_signed <= 1'b0;
    end else begin
      state     <= state_next;
      counter   <= counter_next;
      hi        <= hi_next;
      lo        <= lo_next;
      op_signed <= latch_signed;
      if (latch_en) begin
        op_a <= operand1;
        op_b <= operand2;
      end
    end
  end

  always_comb begin
    case (op)
      OP_MFHI: result = hi;
      OP_MFLO: result = lo;
      default: result = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: a table of directed operations plus
// hand-written sequences for stall, cancel, back-to-back and mid-operation reset.
module tb_mdu_ctrl;

  localparam logic [3:0] NONE  = 4'd0;
  localparam logic [3:0] MULT  = 4'd1;
  localparam logic [3:0] MULTU = 4'd2;
  localparam logic [3:0] DIV   = 4'd3;
  localparam logic [3:0] DIVU  = 4'd4;
  localparam logic [3:0] MTHI  = 4'd5;
  localparam logic [3:0] MTLO  = 4'd6;
  localparam logic [3:0] MFHI  = 4'd7;
  localparam logic [3:0] MFLO  = 4'd8;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  operation;
  logic [31:0] operand1;
  logic [31:0] operand2;
  logic        cancel;
  logic        busy;
  logic        stall;
  logic [31:0] result;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          busy_cycles;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[14];

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .operation (operation),
    .operand1  (operand1),
    .operand2  (operand2),
    .cancel    (cancel),
    .busy      (busy),
    .stall     (stall),
    .result    (result)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  // One-cycle issue; returns at the falling edge of the first cycle after the accept edge.
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic c);
    @(negedge clk);
    start     = 1'b1;
    operation = op;
    operand1  = a;
    operand2  = b;
    cancel    = c;
    @(negedge clk);
    start     = 1'b0;
    operation = NONE;
    cancel    = 1'b0;
  endtask

  task automatic waitBusy(output int cycles);
    cycles = 0;
    #1;
    while (busy && cycles < 50) begin
      cycles++;
      @(negedge clk);
      #1;
    end
  endtask

  task automatic waitStall(output int cycles);
    cycles = 0;
    #1;
    while (stall && cycles < 50) begin
      cycles++;
      @(negedge clk);
      #1;
    end
  endtask

  task automatic readHiLo(input string name, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    start     = 1'b1;
    operation = MFHI;
    #1;
    checkOutput({name, " hi"}, result, exp_hi);
    checkOutput({name, " stall"}, {31'd0, stall}, 32'd0);
    operation = MFLO;
    #1;
    checkOutput({name, " lo"}, result, exp_lo);
    start     = 1'b0;
    operation = NONE;
  endtask

  initial begin
    int n;

    vecs[0]  = '{"mult neg",     MULT,  32'hFFFFFFFD, 32'd7,        5,  32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[1]  = '{"div neg",      DIV,   32'hFFFFFFF9, 32'd2,        10, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[2]  = '{"divu big",     DIVU,  32'hFFFFFFFF, 32'd2,        10, 32'h00000001, 32'h7FFFFFFF};
    vecs[3]  = '{"multu",        MULTU, 32'h12345678, 32'h9ABCDEF0, 5,  32'h0B00EA4E, 32'h242D2080};
    vecs[4]  = '{"mthi",         MTHI,  32'hDEADBEEF, 32'd0,        0,  32'hDEADBEEF, 32'h242D2080};
    vecs[5]  = '{"mtlo",         MTLO,  32'h01234567, 32'd0,        0,  32'hDEADBEEF, 32'h01234567};
    vecs[6]  = '{"div by zero",  DIV,   32'd5,        32'd0,        10, 32'hDEADBEEF, 32'h01234567};
    vecs[7]  = '{"divu by zero", DIVU,  32'd9,        32'd0,        10, 32'hDEADBEEF, 32'h01234567};
    vecs[8]  = '{"div overflow", DIV,   32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000};
    vecs[9]  = '{"div neg dvsr", DIV,   32'd7,        32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD};
    vecs[10] = '{"mult minmin",  MULT,  32'h80000000, 32'h80000000, 5,  32'h40000000, 32'h00000000};
    vecs[11] = '{"multu max",    MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5,  32'hFFFFFFFE, 32'h00000001};
    vecs[12] = '{"divu small",   DIVU,  32'd100,      32'd7,        10, 32'h00000002, 32'h0000000E};
    vecs[13] = '{"op 9 none",    4'd9,  32'd1,        32'd1,        0,  32'h00000002, 32'h0000000E};

    reset     = 1'b1;
    start     = 1'b0;
    operation = NONE;
    operand1  = 32'd0;
    operand2  = 32'd0;
    cancel    = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    checkOutput("reset stall", {31'd0, stall}, 32'd0);
    checkOutput("reset result", result, 32'd0);
    readHiLo("reset", 32'd0, 32'd0);

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0);
      waitBusy(n);
      checkOutput({vecs[i].name, " busy cycles"}, 32'(n), 32'(vecs[i].busy_cycles));
      readHiLo(vecs[i].name, vecs[i].hi, vecs[i].lo);
    end

    // MFLO held behind a MULTU: stalled for the whole latency, then reads the product.
    applyStimulus(MULTU, 32'h12345678, 32'h9ABCDEF0, 1'b0);
    start     = 1'b1;
    operation = MFLO;
    waitStall(n);
    checkOutput("mflo stall cycles", 32'(n), 32'd5);
    readHiLo("multu then mflo", 32'h0B00EA4E, 32'h242D2080);

    // DIV held behind a MULT is accepted on the first non-busy cycle.
    applyStimulus(MULT, 32'd2, 32'd3, 1'b0);
    start     = 1'b1;
    operation = DIV;
    operand1  = 32'd10;
    operand2  = 32'd3;
    waitStall(n);
    checkOutput("b2b stall cycles", 32'(n), 32'd5);
    checkOutput("b2b busy at accept", {31'd0, busy}, 32'd0);
    @(negedge clk);
    start     = 1'b0;
    operation = NONE;
    waitBusy(n);
    checkOutput("b2b div busy cycles", 32'(n), 32'd10);
    readHiLo("b2b div", 32'd1, 32'd3);

    // Cancelled DIV never starts.
    applyStimulus(DIV, 32'd100, 32'd7, 1'b1);
    #1;
    checkOutput("cancel busy", {31'd0, busy}, 32'd0);
    readHiLo("cancel", 32'd1, 32'd3);

    // start && cancel while busy still reports stall and does not queue anything.
    applyStimulus(MULT, 32'd4, 32'd5, 1'b0);
    start     = 1'b1;
    operation = DIV;
    cancel    = 1'b1;
    #1;
    checkOutput("cancel while busy stall", {31'd0, stall}, 32'd1);
    start     = 1'b0;
    operation = NONE;
    cancel    = 1'b0;
    waitBusy(n);
    checkOutput("mult after cancel busy", 32'(n), 32'd5);
    readHiLo("mult 4x5", 32'd0, 32'd20);
    @(negedge clk);
    #1;
    checkOutput("no late div", {31'd0, busy}, 32'd0);

    // Reset in the 4th busy cycle of a DIV.
    applyStimulus(DIV, 32'd100, 32'd7, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("midop reset busy", {31'd0, busy}, 32'd0);
    readHiLo("midop reset", 32'd0, 32'd0);
    applyStimulus(MULT, 32'd2, 32'd3, 1'b0);
    waitBusy(n);
    checkOutput("post reset mult busy", 32'(n), 32'd5);
    readHiLo("post reset mult", 32'd0, 32'd6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
